gcd_job_driver: RTL

Initiator-side sequencer for gcd_machine. Accepts operand pairs from an upstream valid/ready stream, drives the machine's go/in1/in2 and waits for done. Returns each result on a downstream valid/ready stream. Also handles zero operands locally, recovers a hung machine with a timeout-driven reset pulse, and counts completed jobs.

---
 rtl/gcd_job_driver_if.sv | 23 ++
 rtl/gcd_job_driver.sv | 115 +++++++++++
 2 files changed

// File: rtl/gcd_job_driver_if.sv
// Request/response stream bundle between gcd_job_driver and its upstream/downstream clients.
interface gcd_job_driver_if #(parameter int W = 8);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;

    // master: the client side (supplies operands, consumes results)
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // slave: the driver side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/gcd_job_driver.sv
// Sequences operand pairs through a gcd_machine: zero-operand bypass, done-level release,
// timeout recovery reset and a wrapping completed-job counter.
module gcd_job_driver #(
    parameter int W       = 8,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    gcd_job_driver_if.slave  bus,
    output logic             gcd_go,
    output logic [W-1:0]     gcd_in1,
    output logic [W-1:0]     gcd_in2,
    output logic             gcd_rst,
    input  logic [W-1:0]     gcd_out,
    input  logic             gcd_done,
    output logic             busy,
    output logic [CNT_W-1:0] job_count
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_GO, S_WAIT, S_RELEASE, S_RECOVER, S_RESP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_err   = rsp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            gcd_go    <= 1'b0;
            gcd_rst   <= 1'b0;
            gcd_in1   <= '0;
            gcd_in2   <= '0;
            busy      <= 1'b0;
            job_count <= '0;
        end else begin
            gcd_go  <= 1'b0;
            gcd_rst <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        gcd_in1 <= bus.req_a;
                        gcd_in2 <= bus.req_b;
                        busy    <= 1'b1;
                        // gcd(0,b)=b and gcd(0,0)=0 both reduce to a bitwise OR
                        if (bus.req_a == '0 || bus.req_b == '0) begin
                            rsp_data  <= bus.req_a | bus.req_b;
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            gcd_go <= 1'b1;
                            state  <= S_GO;
                        end
                    end
                end
                S_GO: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over an expiring timer
                    if (gcd_done) begin
                        rsp_data <= gcd_out;
                        rsp_err  <= 1'b0;
                        state    <= S_RELEASE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (timer == T_LAST) begin
                            gcd_rst <= 1'b1;
                            state   <= S_RECOVER;
                        end
                    end
                end
                S_RELEASE: begin
                    // hold off until done drops so a held-level done never overlaps the next go
                    if (!gcd_done) begin
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RECOVER: begin
                    rsp_data  <= '0;
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        job_count <= job_count + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
